// File: rtl/stream_lane_converter.sv
// Re-parallelising AXI-stream stage: PE_IN lanes in, PE_OUT lanes out, order kept.
// Optional frame tlast generation via STREAM_LANE_CONVERTER_LAST_EN.
module stream_lane_converter #(
  parameter int W         = 8,
  parameter int PE_IN     = 1,
  parameter int PE_OUT    = 1,
  parameter int FRAME_OUT = 1
) (
  input  logic ap_clk,
  input  logic ap_rst_n,
  output logic s_axis_tready,
  input  logic s_axis_tvalid,
  input  logic [((PE_IN*W+7)/8)*8-1:0] s_axis_tdata,
  input  logic m_axis_tready,
  output logic m_axis_tvalid,
`ifdef STREAM_LANE_CONVERTER_LAST_EN
  output logic m_axis_tlast,
`endif
  output logic [((PE_OUT*W+7)/8)*8-1:0] m_axis_tdata
);

  localparam int MX = (PE_IN > PE_OUT) ? PE_IN : PE_OUT;
  localparam int MN = (PE_IN > PE_OUT) ? PE_OUT : PE_IN;
  localparam int R  = MX / MN;
  localparam int IW = PE_IN * W;
  localparam int OW = PE_OUT * W;

  if (MX % MN != 0) begin : g_chk
    $error("stream_lane_converter: lane counts must divide");
  end

  logic          alive;
  logic          in_hs;
  logic          out_hs;
  logic          ovalid;
  logic [OW-1:0] odata;
  logic [IW-1:0] in_w;
  logic          unused_pad;

  assign in_w       = s_axis_tdata[IW-1:0];
  assign unused_pad = ^s_axis_tdata;
  assign in_hs      = s_axis_tvalid && s_axis_tready;
  assign out_hs     = ovalid && m_axis_tready;

  // Keeps tready low until the first edge after reset release.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) alive <= 1'b0;
    else           alive <= 1'b1;
  end

  if (PE_IN > PE_OUT) begin : g_down
    localparam int KW = $clog2(R);
    logic [IW-1:0] hold_q;
    logic [KW-1:0] k;
    logic          full;
    logic          last;

    assign last          = (k == KW'(R-1));
    assign s_axis_tready = alive && (!full || (last && m_axis_tready));
    assign ovalid        = full;
    assign odata         = hold_q[int'(k)*OW +: OW];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        hold_q <= '0;
        k      <= '0;
        full   <= 1'b0;
      end else if (in_hs) begin
        hold_q <= in_w;
        k      <= '0;
        full   <= 1'b1;
      end else if (out_hs) begin
        if (last) begin
          k    <= '0;
          full <= 1'b0;
        end else begin
          k <= k + 1'b1;
        end
      end
    end
  end else begin : g_up
    // Equal mode is the R==1 case of the assembler.
    localparam int JW = (R > 1) ? $clog2(R) : 1;
    logic [OW-1:0] acc_q;
    logic [OW-1:0] acc_nx;
    logic [OW-1:0] out_q;
    logic [JW-1:0] j;
    logic          out_full;
    logic          jlast;

    assign jlast         = (j == JW'(R-1));
    assign s_axis_tready = alive &&
                           !(jlast && out_full && !m_axis_tready);
    assign ovalid        = out_full;
    assign odata         = out_q;

    always_comb begin
      acc_nx                    = acc_q;
      acc_nx[int'(j)*IW +: IW]  = in_w;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        acc_q    <= '0;
        out_q    <= '0;
        j        <= '0;
        out_full <= 1'b0;
      end else begin
        if (in_hs) begin
          acc_q <= acc_nx;
          if (jlast) j <= '0;
          else       j <= j + 1'b1;
        end
        if (in_hs && jlast) begin
          out_q    <= acc_nx;
          out_full <= 1'b1;
        end else if (out_hs) begin
          out_full <= 1'b0;
        end
      end
    end
  end

  assign m_axis_tvalid = ovalid;

  always_comb begin
    m_axis_tdata         = '0;
    m_axis_tdata[OW-1:0] = odata;
  end

`ifdef STREAM_LANE_CONVERTER_LAST_EN
  localparam int CW = (FRAME_OUT > 1) ? $clog2(FRAME_OUT) : 1;
  logic [CW-1:0] beat;
  logic          beat_last;

  assign beat_last    = (beat == CW'(FRAME_OUT-1));
  assign m_axis_tlast = ovalid && beat_last;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)   beat <= '0;
    else if (out_hs) beat <= beat_last ? '0 : beat + 1'b1;
  end
`else
  localparam int unused_frame = FRAME_OUT;
`endif

endmodule
